ddr4_cmd_scheduler: RTL and testbench
=====================================

# ddr4_cmd_scheduler

Single-requester DDR4 command scheduler between the LLC and `ddr4_dimm`. It accepts one read or write request at a time and tracks the open row of each of the 16 banks (open-page policy). It issues ACT/RD/WR/PRE/REF commands with the DIMM's activation, precharge and CAS latencies, and drives or captures the data bus. Periodic refresh is inserted every REFRESH_CYCLE cycles.

## Interface
- CAS_LATENCY, 22, cycles from RD/WR issue to the data-bus cycle (≥1)
- ACTIVATION_LATENCY, 8, minimum cycles from ACT to RD/WR on the same bank (≥1)
- PRECHARGE_LATENCY, 5, minimum cycles from PRE/PREA to the next ACT/REF (≥1)
- REFRESH_LATENCY, 16, minimum cycles from REF to the next command (≥1)
- REFRESH_CYCLE, 5120, refresh interval in cycles
- ROW_BITS, 8, row address width (≤14)
- COL_BITS, 4, column address width (≤10)

Clocking: one clock; reset is synchronous and active-high.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous active-high reset
- req_valid_in  in  1  request valid
- req_ready_out  out  1  scheduler can accept a request
- req_write_in  in  1  1=write, 0=read
- req_bg_in / req_ba_in  in  2 / 2  bank group / bank
- req_row_in  in  ROW_BITS  row
- req_col_in  in  COL_BITS  column
- req_wdata_in  in  64  write data
- req_wmask_in  in  64  write mask (1 = byte lane blocked)
- resp_valid_out  out  1  one-cycle pulse; read data valid or write done
- resp_rdata_out  out  64  read data
- cs_N_out, cke_out, act_N_out  out  1 each  DIMM command pins
- addr_out  out  17  DIMM address; [16:14] = {ras_n, cas_n, we_n} when act_N_out=1
- bg_out, ba_out  out  2 each  DIMM bank group / bank
- dqm_out  out  64  DIMM data mask
- dq_out  out  64  write data to the DIMM
- dq_oe_out  out  1  output enable for the DIMM data bus
- dq_in  in  64  read data from the DIMM

## Operation
- **Command encoding.** A command occupies one cycle with cs_N_out=0. All other cycles are deselect: cs_N_out=1, act_N_out=1, addr_out=0.
  - ACT: act_N_out=0, addr_out={zeros, row}.
  - RD: addr_out[16:14]=101, addr_out[COL_BITS-1:0]=col.
  - WR: addr_out[16:14]=100, addr_out[COL_BITS-1:0]=col.
  - PRE: addr_out[16:14]=010, addr_out[10]=0.
  - PREA: addr_out[16:14]=010, addr_out[10]=1.
  - REF: addr_out[16:14]=001.
- **Bank table.** One entry per index {bg,ba}: open_valid plus open_row.
  - ACT sets the entry.
  - PRE clears the entry.
  - PREA and reset clear all entries.
- **FSM states:** IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, CAS, WAIT_CL, RESP, REF_PREA, REF_WAIT_RP, REF, REF_WAIT_RFC.
- **IDLE.** req_ready_out = (state==IDLE && !ref_pending && !rst_in).
  - If ref_pending: go to REF_PREA if any bank is open, else go to REF.
  - Else, on accept (req_valid_in && req_ready_out): latch the request, then:
    - row hit → CAS
    - bank closed → ACT
    - row conflict → PRE
- **Transitions.**
  - PRE → WAIT_RP → ACT
  - ACT → WAIT_RCD → CAS
  - CAS → WAIT_CL → RESP → IDLE
  - REF_PREA → REF_WAIT_RP → REF → REF_WAIT_RFC → IDLE
- **Refresh counter.**
  - Counts every cycle from 0. At REFRESH_CYCLE-1 it sets ref_pending and wraps to 0.
  - Entering REF clears ref_pending.
  - Refresh never preempts an accepted request; it waits for IDLE.
  - Refresh has priority over a request presented in the same IDLE cycle.
- **Write data.** In the data cycle: dq_oe_out=1, dq_out=wdata, dqm_out=wmask. Otherwise dq_oe_out=0 and dqm_out=0.
- **Reset mid-operation.** Abort all activity on the next edge:
  - Bank table cleared, refresh counter and ref_pending cleared.
  - No resp_valid_out is produced for the aborted request.
  - dq_oe_out=0.

## Timing
- **Reset values:**
  - cs_N_out=1, act_N_out=1, cke_out=0, addr_out=0, bg_out=0, ba_out=0
  - dqm_out=0, dq_out=0, dq_oe_out=0
  - resp_valid_out=0, resp_rdata_out=0, req_ready_out=0
  - state=IDLE
- cke_out=1 from the first cycle after rst_in deasserts. req_ready_out may be 1 in that same cycle.
- **Command spacing.**
  - A command issued in cycle t allows the next dependent command at t+LATENCY.
  - All commands are registered outputs.
- **Accept-to-command.** For a request accepted in cycle t0:
  - First command is issued at t0+1.
  - Hit: RD/WR at t0+1.
  - Closed: ACT at t0+1, RD/WR at t0+1+ACTIVATION_LATENCY.
  - Conflict: PRE at t0+1, ACT at t0+1+PRECHARGE_LATENCY, RD/WR a further ACTIVATION_LATENCY later.
- **Data and response.** For RD/WR issued in cycle t:
  - Data cycle is t+CAS_LATENCY. A read samples dq_in on that edge; a write drives the bus in that cycle.
  - resp_valid_out pulses at t+CAS_LATENCY+1 (resp_rdata_out valid for reads).
  - req_ready_out returns the next cycle.
- Default latencies, accept to resp_valid_out: hit 24, closed 32, conflict 37.
- Refresh: PREA at r, REF at r+PRECHARGE_LATENCY, IDLE at REF+REFRESH_LATENCY.

## Test plan
- **Reset values.** Hold rst_in 3 cycles.
  - All outputs at their reset values; cke_out=1 and req_ready_out=1 one cycle after release.
- **Closed-bank read.** Read bg=1 ba=2 row=0x3C col=5, accepted at t0; dq_in=0xDEADBEEF_01234567 at t0+31.
  - ACT at t0+1 with addr_out=0x003C.
  - RD at t0+9 with addr_out=0x14005.
  - resp_valid_out at t0+32 with rdata=0xDEADBEEF_01234567.
- **Row-hit write.** Write to the same bank/row, col=7, wdata=0xA5A5…, wmask=0xFF.
  - WR at t0+1.
  - dq_oe_out=1, dq_out=0xA5A5…, dqm_out=0xFF at t0+23.
  - resp_valid_out at t0+24.
- **Row conflict.** Read row=0x3D on that bank.
  - PRE at t0+1, ACT row 0x3D at t0+6, RD at t0+14.
  - resp_valid_out at t0+37.
- **Refresh interval.** REFRESH_CYCLE=64, one bank open, request held valid when ref_pending rises.
  - PREA (addr_out[10]=1), REF 5 cycles later.
  - req_ready_out=0 until REF+16.
  - Then the request's ACT is issued (bank table was cleared).
- **Reset mid-read.** Assert rst_in during WAIT_CL.
  - No resp_valid_out.
  - Next read to the previously open row issues ACT, not RD.

Source files
------------

// File: rtl/ddr4_cmd_scheduler.sv
// ddr4_cmd_scheduler
// Single-requester open-page DDR4 command scheduler between the LLC and the DIMM.
// Accepts one read/write at a time, tracks the open row of all 16 banks and
// issues ACT/RD/WR/PRE/PREA/REF with fixed latencies. It also drives or captures
// the data bus and inserts a refresh every REFRESH_CYCLE cycles.
// Ports:
//   clk_in, rst_in                   clock, synchronous active-high reset
//   req_*                            request handshake, address and write data/mask
//   resp_valid_out, resp_rdata_out   one-cycle completion pulse, read data
//   cs_N_out..ba_out                 DIMM command/address pins (registered)
//   dqm_out, dq_out, dq_oe_out       DIMM write data path (registered)
//   dq_in                            DIMM read data
module ddr4_cmd_scheduler #(
  parameter int CAS_LATENCY        = 22,
  parameter int ACTIVATION_LATENCY = 8,
  parameter int PRECHARGE_LATENCY  = 5,
  parameter int REFRESH_LATENCY    = 16,
  parameter int REFRESH_CYCLE      = 5120,
  parameter int ROW_BITS           = 8,
  parameter int COL_BITS           = 4
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                req_valid_in,
  output logic                req_ready_out,
  input  logic                req_write_in,
  input  logic [1:0]          req_bg_in,
  input  logic [1:0]          req_ba_in,
  input  logic [ROW_BITS-1:0] req_row_in,
  input  logic [COL_BITS-1:0] req_col_in,
  input  logic [63:0]         req_wdata_in,
  input  logic [63:0]         req_wmask_in,
  output logic                resp_valid_out,
  output logic [63:0]         resp_rdata_out,
  output logic                cs_N_out,
  output logic                cke_out,
  output logic                act_N_out,
  output logic [16:0]         addr_out,
  output logic [1:0]          bg_out,
  output logic [1:0]          ba_out,
  output logic [63:0]         dqm_out,
  output logic [63:0]         dq_out,
  output logic                dq_oe_out,
  input  logic [63:0]         dq_in
);

  localparam int CNT_W = 16;
  localparam int REF_W = $clog2(REFRESH_CYCLE) + 1;

  // Command states (PRE, ACT, CAS, REF_PREA, REF) are the cycle in which that
  // command is on the pins; the command is registered on the edge entering them.
  typedef enum logic [3:0] {
    IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, CAS, WAIT_CL, RESP,
    REF_PREA, REF_WAIT_RP, REF, REF_WAIT_RFC
  } state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [REF_W-1:0]           ref_cnt_q, ref_cnt_d;
  logic                       ref_pending_q, ref_pending_d;
  logic [15:0]                open_valid_q, open_valid_d;
  logic [15:0][ROW_BITS-1:0]  open_row_q, open_row_d;
  logic                       req_write_q, req_write_d;
  logic [3:0]                 req_bank_q, req_bank_d;
  logic [ROW_BITS-1:0]        req_row_q, req_row_d;
  logic [COL_BITS-1:0]        req_col_q, req_col_d;
  logic [63:0]                req_wdata_q, req_wdata_d;
  logic [63:0]                req_wmask_q, req_wmask_d;
  logic                       cs_n_q, cs_n_d, act_n_q, act_n_d, cke_q;
  logic [16:0]                addr_q, addr_d;
  logic [1:0]                 bg_q, bg_d, ba_q, ba_d;
  logic [63:0]                dqm_q, dqm_d, dq_q, dq_d;
  logic                       dq_oe_q, dq_oe_d;
  logic                       resp_valid_q, resp_valid_d;
  logic [63:0]                resp_rdata_q, resp_rdata_d;

  logic                       do_act, do_cas, do_pre, do_prea, do_ref;
  logic                       idle;
  logic [3:0]                 sel_bank;
  logic [ROW_BITS-1:0]        sel_row;
  logic [COL_BITS-1:0]        sel_col;
  logic                       sel_write;

  // In IDLE the command for a just-accepted request comes straight from the inputs.
  assign idle      = (state_q == IDLE);
  assign sel_bank  = idle ? {req_bg_in, req_ba_in} : req_bank_q;
  assign sel_row   = idle ? req_row_in : req_row_q;
  assign sel_col   = idle ? req_col_in : req_col_q;
  assign sel_write = idle ? req_write_in : req_write_q;

  assign req_ready_out = idle && !ref_pending_q && !rst_in;

  always_comb begin
    state_d       = state_q;
    cnt_d         = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
    ref_pending_d = ref_pending_q;
    ref_cnt_d     = ref_cnt_q + REF_W'(1);
    open_valid_d  = open_valid_q;
    open_row_d    = open_row_q;
    req_write_d   = req_write_q;
    req_bank_d    = req_bank_q;
    req_row_d     = req_row_q;
    req_col_d     = req_col_q;
    req_wdata_d   = req_wdata_q;
    req_wmask_d   = req_wmask_q;
    cs_n_d        = 1'b1;
    act_n_d       = 1'b1;
    addr_d        = '0;
    bg_d          = '0;
    ba_d          = '0;
    dqm_d         = '0;
    dq_d          = '0;
    dq_oe_d       = 1'b0;
    resp_valid_d  = 1'b0;
    resp_rdata_d  = resp_rdata_q;
    do_act        = 1'b0;
    do_cas        = 1'b0;
    do_pre        = 1'b0;
    do_prea       = 1'b0;
    do_ref        = 1'b0;

    case (state_q)
      IDLE: begin
        if (ref_pending_q) begin
          if (|open_valid_q) begin
            state_d = REF_PREA;
            do_prea = 1'b1;
            cnt_d   = CNT_W'(PRECHARGE_LATENCY);
          end else begin
            state_d       = REF;
            do_ref        = 1'b1;
            ref_pending_d = 1'b0;
            cnt_d         = CNT_W'(REFRESH_LATENCY);
          end
        end else if (req_valid_in && req_ready_out) begin
          req_write_d = req_write_in;
          req_bank_d  = sel_bank;
          req_row_d   = req_row_in;
          req_col_d   = req_col_in;
          req_wdata_d = req_wdata_in;
          req_wmask_d = req_wmask_in;
          if (open_valid_q[sel_bank] && (open_row_q[sel_bank] == sel_row)) begin
            state_d = CAS;
            do_cas  = 1'b1;
            cnt_d   = CNT_W'(CAS_LATENCY);
          end else if (!open_valid_q[sel_bank]) begin
            state_d = ACT;
            do_act  = 1'b1;
            cnt_d   = CNT_W'(ACTIVATION_LATENCY);
          end else begin
            state_d = PRE;
            do_pre  = 1'b1;
            cnt_d   = CNT_W'(PRECHARGE_LATENCY);
          end
        end
      end
      // cnt counts down from the latency; reaching 1 means the next edge may issue.
      PRE, WAIT_RP: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ACT;
          do_act  = 1'b1;
          cnt_d   = CNT_W'(ACTIVATION_LATENCY);
        end else begin
          state_d = WAIT_RP;
        end
      end
      ACT, WAIT_RCD: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = CAS;
          do_cas  = 1'b1;
          cnt_d   = CNT_W'(CAS_LATENCY);
        end else begin
          state_d = WAIT_RCD;
        end
      end
      // cnt==1: next cycle is the data cycle; cnt==0 in WAIT_CL: this is it.
      CAS, WAIT_CL: begin
        if (state_q == WAIT_CL && cnt_q == '0) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          if (!req_write_q) resp_rdata_d = dq_in;
        end else begin
          state_d = WAIT_CL;
          if (cnt_q == CNT_W'(1) && req_write_q) begin
            dq_oe_d = 1'b1;
            dq_d    = req_wdata_q;
            dqm_d   = req_wmask_q;
          end
        end
      end
      RESP: state_d = IDLE;
      REF_PREA, REF_WAIT_RP: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d       = REF;
          do_ref        = 1'b1;
          ref_pending_d = 1'b0;
          cnt_d         = CNT_W'(REFRESH_LATENCY);
        end else begin
          state_d = REF_WAIT_RP;
        end
      end
      REF, REF_WAIT_RFC: begin
        state_d = (cnt_q == CNT_W'(1)) ? IDLE : REF_WAIT_RFC;
      end
      default: state_d = IDLE;
    endcase

    // A wrap coinciding with REF entry starts a new interval, so set wins.
    if (ref_cnt_q == REF_W'(REFRESH_CYCLE - 1)) begin
      ref_cnt_d     = '0;
      ref_pending_d = 1'b1;
    end

    if (do_act) begin
      cs_n_d                  = 1'b0;
      act_n_d                 = 1'b0;
      addr_d[ROW_BITS-1:0]    = sel_row;
      bg_d                    = sel_bank[3:2];
      ba_d                    = sel_bank[1:0];
      open_valid_d[sel_bank]  = 1'b1;
      open_row_d[sel_bank]    = sel_row;
    end
    if (do_cas) begin
      cs_n_d                  = 1'b0;
      addr_d[16:14]           = sel_write ? 3'b100 : 3'b101;
      addr_d[COL_BITS-1:0]    = sel_col;
      bg_d                    = sel_bank[3:2];
      ba_d                    = sel_bank[1:0];
    end
    if (do_pre) begin
      cs_n_d                  = 1'b0;
      addr_d[16:14]           = 3'b010;
      bg_d                    = sel_bank[3:2];
      ba_d                    = sel_bank[1:0];
      open_valid_d[sel_bank]  = 1'b0;
    end
    if (do_prea) begin
      cs_n_d                  = 1'b0;
      addr_d[16:14]           = 3'b010;
      addr_d[10]              = 1'b1;
      open_valid_d            = '0;
    end
    if (do_ref) begin
      cs_n_d                  = 1'b0;
      addr_d[16:14]           = 3'b001;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      ref_cnt_q     <= '0;
      ref_pending_q <= 1'b0;
      open_valid_q  <= '0;
      open_row_q    <= '0;
      req_write_q   <= 1'b0;
      req_bank_q    <= '0;
      req_row_q     <= '0;
      req_col_q     <= '0;
      req_wdata_q   <= '0;
      req_wmask_q   <= '0;
      cs_n_q        <= 1'b1;
      act_n_q       <= 1'b1;
      cke_q         <= 1'b0;
      addr_q        <= '0;
      bg_q          <= '0;
      ba_q          <= '0;
      dqm_q         <= '0;
      dq_q          <= '0;
      dq_oe_q       <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ref_cnt_q     <= ref_cnt_d;
      ref_pending_q <= ref_pending_d;
      open_valid_q  <= open_valid_d;
      open_row_q    <= open_row_d;
      req_write_q   <= req_write_d;
      req_bank_q    <= req_bank_d;
      req_row_q     <= req_row_d;
      req_col_q     <= req_col_d;
      req_wdata_q   <= req_wdata_d;
      req_wmask_q   <= req_wmask_d;
      cs_n_q        <= cs_n_d;
      act_n_q       <= act_n_d;
      cke_q         <= 1'b1;
      addr_q        <= addr_d;
      bg_q          <= bg_d;
      ba_q          <= ba_d;
      dqm_q         <= dqm_d;
      dq_q          <= dq_d;
      dq_oe_q       <= dq_oe_d;
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
    end
  end

  assign cs_N_out       = cs_n_q;
  assign cke_out        = cke_q;
  assign act_N_out      = act_n_q;
  assign addr_out       = addr_q;
  assign bg_out         = bg_q;
  assign ba_out         = ba_q;
  assign dqm_out        = dqm_q;
  assign dq_out         = dq_q;
  assign dq_oe_out      = dq_oe_q;
  assign resp_valid_out = resp_valid_q;
  assign resp_rdata_out = resp_rdata_q;

endmodule

// File: tb/tb_ddr4_cmd_scheduler.sv
// Directed bench for ddr4_cmd_scheduler. Instance a uses default parameters;
// instance b shares the stimulus but refreshes every 64 cycles.
module tb_ddr4_cmd_scheduler;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [1:0]  req_bg = '0, req_ba = '0;
  logic [7:0]  req_row = '0;
  logic [3:0]  req_col = '0;
  logic [63:0] req_wdata = '0, req_wmask = '0, dq_in = '0;

  logic        a_ready, a_resp_valid, a_cs_n, a_cke, a_act_n, a_dq_oe;
  logic [63:0] a_rdata, a_dqm, a_dq;
  logic [16:0] a_addr;
  logic [1:0]  a_bg, a_ba;
  logic        b_ready, b_resp_valid, b_cs_n, b_cke, b_act_n, b_dq_oe;
  logic [63:0] b_rdata, b_dqm, b_dq;
  logic [16:0] b_addr;
  logic [1:0]  b_bg, b_ba;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ddr4_cmd_scheduler dut_a (
    .clk_in(clk), .rst_in(rst_in), .req_valid_in(req_valid), .req_ready_out(a_ready),
    .req_write_in(req_write), .req_bg_in(req_bg), .req_ba_in(req_ba), .req_row_in(req_row),
    .req_col_in(req_col), .req_wdata_in(req_wdata), .req_wmask_in(req_wmask),
    .resp_valid_out(a_resp_valid), .resp_rdata_out(a_rdata), .cs_N_out(a_cs_n),
    .cke_out(a_cke), .act_N_out(a_act_n), .addr_out(a_addr), .bg_out(a_bg), .ba_out(a_ba),
    .dqm_out(a_dqm), .dq_out(a_dq), .dq_oe_out(a_dq_oe), .dq_in(dq_in)
  );

  ddr4_cmd_scheduler #(.REFRESH_CYCLE(64)) dut_b (
    .clk_in(clk), .rst_in(rst_in), .req_valid_in(req_valid), .req_ready_out(b_ready),
    .req_write_in(req_write), .req_bg_in(req_bg), .req_ba_in(req_ba), .req_row_in(req_row),
    .req_col_in(req_col), .req_wdata_in(req_wdata), .req_wmask_in(req_wmask),
    .resp_valid_out(b_resp_valid), .resp_rdata_out(b_rdata), .cs_N_out(b_cs_n),
    .cke_out(b_cke), .act_N_out(b_act_n), .addr_out(b_addr), .bg_out(b_bg), .ba_out(b_ba),
    .dqm_out(b_dqm), .dq_out(b_dq), .dq_oe_out(b_dq_oe), .dq_in(dq_in)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({a_cs_n, a_act_n, a_cke, a_addr, a_bg, a_ba} !== {1'b1, 1'b1, 1'b0, 17'h0, 2'b0, 2'b0}) begin
      n_fail++;
      $display("FAIL reset_cmd: got cs=%b act=%b cke=%b addr=%h bg=%h ba=%h, want 1 1 0 0 0 0",
               a_cs_n, a_act_n, a_cke, a_addr, a_bg, a_ba);
    end
    n_checks++;
    if ({a_dqm, a_dq, a_dq_oe, a_resp_valid, a_rdata, a_ready} !== {64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_data: got dqm=%h dq=%h oe=%b rv=%b rdata=%h ready=%b, want all 0",
               a_dqm, a_dq, a_dq_oe, a_resp_valid, a_rdata, a_ready);
    end
    rst_in = 1'b0;
    tick();
    n_checks++;
    if ({a_cke, a_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_release: got cke=%b ready=%b, want 1 1", a_cke, a_ready);
    end
  endtask

  task automatic test_closed_read();
    logic [18:0] exp_cmd;
    req_valid = 1'b1; req_write = 1'b0; req_bg = 2'd1; req_ba = 2'd2;
    req_row = 8'h3C; req_col = 4'h5;
    n_checks++;
    if (a_ready !== 1'b1) begin n_fail++; $display("FAIL closed_accept: ready=%b want 1", a_ready); end
    for (int k = 1; k <= 33; k++) begin
      tick();
      req_valid = 1'b0;
      dq_in = (k == 31) ? 64'hDEADBEEF_01234567 : 64'h0;
      exp_cmd = (k == 1) ? {2'b00, 17'h0003C} : (k == 9) ? {2'b01, 17'h14005} : {2'b11, 17'h0};
      n_checks++;
      if ({a_cs_n, a_act_n, a_addr} !== exp_cmd) begin
        n_fail++;
        $display("FAIL closed_cmd k=%0d: got %h want %h", k, {a_cs_n, a_act_n, a_addr}, exp_cmd);
      end
      if (k == 1 || k == 9) begin
        n_checks++;
        if ({a_bg, a_ba} !== 4'b0110) begin n_fail++; $display("FAIL closed_bank k=%0d: got %b want 0110", k, {a_bg, a_ba}); end
      end
      n_checks++;
      if (a_resp_valid !== (k == 32)) begin n_fail++; $display("FAIL closed_resp k=%0d: got %b want %b", k, a_resp_valid, k == 32); end
      if (k == 32) begin
        n_checks++;
        if (a_rdata !== 64'hDEADBEEF_01234567) begin n_fail++; $display("FAIL closed_rdata: got %h want deadbeef01234567", a_rdata); end
      end
      n_checks++;
      if (a_ready !== (k == 33)) begin n_fail++; $display("FAIL closed_ready k=%0d: got %b want %b", k, a_ready, k == 33); end
    end
  endtask

  task automatic test_hit_write();
    logic [18:0] exp_cmd;
    req_valid = 1'b1; req_write = 1'b1; req_bg = 2'd1; req_ba = 2'd2;
    req_row = 8'h3C; req_col = 4'h7; req_wdata = {8{8'hA5}}; req_wmask = 64'hFF;
    for (int k = 1; k <= 25; k++) begin
      tick();
      req_valid = 1'b0;
      exp_cmd = (k == 1) ? {2'b01, 17'h10007} : {2'b11, 17'h0};
      n_checks++;
      if ({a_cs_n, a_act_n, a_addr} !== exp_cmd) begin
        n_fail++;
        $display("FAIL hit_cmd k=%0d: got %h want %h", k, {a_cs_n, a_act_n, a_addr}, exp_cmd);
      end
      n_checks++;
      if (a_dq_oe !== (k == 23)) begin n_fail++; $display("FAIL hit_oe k=%0d: got %b want %b", k, a_dq_oe, k == 23); end
      if (k == 23) begin
        n_checks++;
        if ({a_dq, a_dqm} !== {{8{8'hA5}}, 64'hFF}) begin
          n_fail++;
          $display("FAIL hit_wdata: got dq=%h dqm=%h want a5a5a5a5a5a5a5a5 ff", a_dq, a_dqm);
        end
      end
      n_checks++;
      if (a_resp_valid !== (k == 24)) begin n_fail++; $display("FAIL hit_resp k=%0d: got %b want %b", k, a_resp_valid, k == 24); end
    end
  endtask

  task automatic test_conflict_read();
    logic [18:0] exp_cmd;
    req_valid = 1'b1; req_write = 1'b0; req_bg = 2'd1; req_ba = 2'd2;
    req_row = 8'h3D; req_col = 4'h2;
    for (int k = 1; k <= 38; k++) begin
      tick();
      req_valid = 1'b0;
      dq_in = (k == 36) ? 64'h01234567_89ABCDEF : 64'h0;
      exp_cmd = (k == 1)  ? {2'b01, 17'h08000} :
                (k == 6)  ? {2'b00, 17'h0003D} :
                (k == 14) ? {2'b01, 17'h14002} : {2'b11, 17'h0};
      n_checks++;
      if ({a_cs_n, a_act_n, a_addr} !== exp_cmd) begin
        n_fail++;
        $display("FAIL conflict_cmd k=%0d: got %h want %h", k, {a_cs_n, a_act_n, a_addr}, exp_cmd);
      end
      n_checks++;
      if (a_resp_valid !== (k == 37)) begin n_fail++; $display("FAIL conflict_resp k=%0d: got %b want %b", k, a_resp_valid, k == 37); end
      if (k == 37) begin
        n_checks++;
        if (a_rdata !== 64'h01234567_89ABCDEF) begin n_fail++; $display("FAIL conflict_rdata: got %h want 0123456789abcdef", a_rdata); end
      end
      n_checks++;
      if (a_ready !== (k == 38)) begin n_fail++; $display("FAIL conflict_ready k=%0d: got %b want %b", k, a_ready, k == 38); end
    end
  endtask

  task automatic test_reset_mid_read();
    req_valid = 1'b1; req_write = 1'b0; req_bg = 2'd1; req_ba = 2'd2;
    req_row = 8'h3D; req_col = 4'h1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      req_valid = 1'b0;
      rst_in = (k == 10 || k == 11);
      if (k == 1) begin
        n_checks++;
        if ({a_cs_n, a_act_n, a_addr} !== {2'b01, 17'h14001}) begin
          n_fail++;
          $display("FAIL midrst_rd: got %h want %h", {a_cs_n, a_act_n, a_addr}, {2'b01, 17'h14001});
        end
      end else begin
        n_checks++;
        if ({a_resp_valid, a_dq_oe} !== 2'b00) begin
          n_fail++;
          $display("FAIL midrst_quiet k=%0d: got rv=%b oe=%b want 0 0", k, a_resp_valid, a_dq_oe);
        end
      end
    end
    req_valid = 1'b1;
    n_checks++;
    if (a_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b want 1", a_ready); end
    tick();
    req_valid = 1'b0;
    n_checks++;
    if ({a_cs_n, a_act_n, a_addr} !== {2'b00, 17'h0003D}) begin
      n_fail++;
      $display("FAIL midrst_act: got %h want %h", {a_cs_n, a_act_n, a_addr}, {2'b00, 17'h0003D});
    end
  endtask

  task automatic test_refresh();
    logic [18:0] exp_cmd;
    rst_in = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({b_cs_n, b_act_n, b_cke, b_addr, b_bg, b_ba, b_dqm, b_dq, b_dq_oe, b_resp_valid, b_rdata, b_ready} !==
        {1'b1, 1'b1, 1'b0, 17'h0, 4'h0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL refresh_reset: got cs=%b act=%b cke=%b addr=%h oe=%b rv=%b ready=%b, want reset values",
               b_cs_n, b_act_n, b_cke, b_addr, b_dq_oe, b_resp_valid, b_ready);
    end
    rst_in = 1'b0;
    repeat (40) tick();
    req_valid = 1'b1; req_write = 1'b0; req_bg = 2'd1; req_ba = 2'd2;
    req_row = 8'h3C; req_col = 4'h5;
    n_checks++;
    if (b_ready !== 1'b1) begin n_fail++; $display("FAIL refresh_first_accept: got %b want 1", b_ready); end
    for (int k = 1; k <= 56; k++) begin
      tick();
      if (k == 1) begin
        req_bg = 2'd0; req_ba = 2'd3; req_row = 8'h55; req_col = 4'h3;
      end
      if (k == 56) req_valid = 1'b0;
      exp_cmd = (k == 1)  ? {2'b00, 17'h0003C} :
                (k == 9)  ? {2'b01, 17'h14005} :
                (k == 34) ? {2'b01, 17'h08400} :
                (k == 39) ? {2'b01, 17'h04000} :
                (k == 56) ? {2'b00, 17'h00055} : {2'b11, 17'h0};
      n_checks++;
      if ({b_cs_n, b_act_n, b_addr} !== exp_cmd) begin
        n_fail++;
        $display("FAIL refresh_cmd k=%0d: got %h want %h", k, {b_cs_n, b_act_n, b_addr}, exp_cmd);
      end
      if (k == 56) begin
        n_checks++;
        if ({b_bg, b_ba} !== 4'b0011) begin n_fail++; $display("FAIL refresh_act_bank: got %b want 0011", {b_bg, b_ba}); end
      end
      n_checks++;
      if (b_ready !== (k == 55)) begin n_fail++; $display("FAIL refresh_ready k=%0d: got %b want %b", k, b_ready, k == 55); end
      n_checks++;
      if (b_resp_valid !== (k == 32)) begin n_fail++; $display("FAIL refresh_resp k=%0d: got %b want %b", k, b_resp_valid, k == 32); end
    end
  endtask

  initial begin
    test_reset();
    test_closed_read();
    test_hit_write();
    test_conflict_read();
    test_reset_mid_read();
    test_refresh();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
